eth_tx_arbiter: RTL

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter_if.sv | 33 +++
 rtl/eth_tx_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter_if.sv
// Request / TX-tap / status bundle for eth_tx_arbiter.
//   master : packet sources and MAC side (drives requests and the TX tap, observes status)
//   slave  : the arbiter (samples requests and the TX tap, drives select and status)
//   i_arp_req, i_ping_req, i_udp_req : per-source "packet ready", held until first beat accepted
//   i_tx_vld, i_tx_sop, i_tx_eop     : tap of the muxed TX stream after the output switch
//   i_tx_rdy                         : MAC ready; beat accepted when vld & rdy
//   o_pkt_type                       : source select (NONE 0, ARP 1, UDP 2, PING 3)
//   o_busy, o_timeout                : not-idle flag, one-cycle forced-release pulse
//   o_pkt_cnt, o_to_cnt              : completed packets (wraps), forced releases (saturates)
interface eth_tx_arbiter_if;
  logic        i_arp_req;
  logic        i_ping_req;
  logic        i_udp_req;
  logic        i_tx_vld;
  logic        i_tx_sop;
  logic        i_tx_eop;
  logic        i_tx_rdy;
  logic [1:0]  o_pkt_type;
  logic        o_busy;
  logic        o_timeout;
  logic [15:0] o_pkt_cnt;
  logic [7:0]  o_to_cnt;

  modport master (
    output i_arp_req, i_ping_req, i_udp_req, i_tx_vld, i_tx_sop, i_tx_eop, i_tx_rdy,
    input  o_pkt_type, o_busy, o_timeout, o_pkt_cnt, o_to_cnt
  );

  modport slave (
    input  i_arp_req, i_ping_req, i_udp_req, i_tx_vld, i_tx_sop, i_tx_eop, i_tx_rdy,
    output o_pkt_type, o_busy, o_timeout, o_pkt_cnt, o_to_cnt
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Ethernet TX source arbiter: picks one of ARP / PING / UDP, holds the output switch on it
// until the packet's eop is accepted (or an idle timeout forces release), then inserts a
// fixed PT_NONE gap before arbitrating again.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : eth_tx_arbiter_if.slave (requests, TX tap, select and status outputs)
module eth_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  eth_tx_arbiter_if.slave bus
);

  localparam logic [1:0] PtNone = 2'd0;
  localparam logic [1:0] PtArp  = 2'd1;
  localparam logic [1:0] PtUdp  = 2'd2;
  localparam logic [1:0] PtPing = 2'd3;

  localparam int unsigned IdleW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StGap} state_e;

  state_e               state_q, state_d;
  logic [1:0]           type_q, type_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic [IdleW-1:0]     idle_q, idle_d;
  logic [3:0]           gap_q, gap_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic [7:0]           to_cnt_q, to_cnt_d;
  logic                 timeout_q, timeout_d;

  logic       beat_acc;
  logic       any_req;
  logic       active;
  logic       expire;
  logic       pkt_done;
  logic [1:0] winner;

  assign beat_acc = bus.i_tx_vld & bus.i_tx_rdy;
  assign any_req  = bus.i_arp_req | bus.i_ping_req | bus.i_udp_req;
  assign active   = (state_q == StGrant) || (state_q == StXfer);
  // Any accepted beat restarts the idle window, so an eop landing on the expiry cycle wins.
  assign expire   = active && !beat_acc && (idle_q == IdleW'(TIMEOUT_CYC - 1));
  assign pkt_done = beat_acc && bus.i_tx_eop &&
                    (((state_q == StGrant) && bus.i_tx_sop) || (state_q == StXfer));

  // Fixed priority with a starvation override for UDP.
  always_comb begin
    winner = PtNone;
    if (bus.i_udp_req && (starve_q == StarveW'(STARVE_MAX))) begin
      winner = PtUdp;
    end else if (bus.i_arp_req) begin
      winner = PtArp;
    end else if (bus.i_ping_req) begin
      winner = PtPing;
    end else if (bus.i_udp_req) begin
      winner = PtUdp;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) state_d = StGrant;
      end
      StGrant: begin
        // Beats without sop are ignored here; only a real packet start moves on.
        if (beat_acc && bus.i_tx_sop) begin
          state_d = bus.i_tx_eop ? StGap : StXfer;
        end else if (expire) begin
          state_d = StGap;
        end
      end
      StXfer: begin
        if (beat_acc && bus.i_tx_eop) begin
          state_d = StGap;
        end else if (expire) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == 4'(GAP_CYC - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.o_pkt_type = active ? type_q : PtNone;
    bus.o_busy     = (state_q != StIdle);
    bus.o_timeout  = timeout_q;
    bus.o_pkt_cnt  = pkt_cnt_q;
    bus.o_to_cnt   = to_cnt_q;
  end

  // Datapath next-state
  always_comb begin
    type_d    = type_q;
    starve_d  = starve_q;
    if ((state_q == StIdle) && any_req) begin
      type_d = winner;
      if (winner == PtUdp) begin
        starve_d = '0;
      end else if (bus.i_udp_req && (starve_q != StarveW'(STARVE_MAX))) begin
        starve_d = starve_q + 1'b1;
      end
    end

    idle_d    = (active && !beat_acc && !expire) ? idle_q + 1'b1 : '0;
    gap_d     = ((state_q == StGap) && (state_d == StGap)) ? gap_q + 4'd1 : 4'd0;
    pkt_cnt_d = pkt_cnt_q + {15'd0, pkt_done};
    timeout_d = expire;
    to_cnt_d  = (expire && (to_cnt_q != 8'hFF)) ? to_cnt_q + 8'd1 : to_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      type_q    <= PtNone;
      starve_q  <= '0;
      idle_q    <= '0;
      gap_q     <= 4'd0;
      pkt_cnt_q <= 16'd0;
      to_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      type_q    <= type_d;
      starve_q  <= starve_d;
      idle_q    <= idle_d;
      gap_q     <= gap_d;
      pkt_cnt_q <= pkt_cnt_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
